// File: rtl/doc5503_osc_sequencer_if.sv
// Bundle of the oscillator sequencer's tick, register-RAM port A, priority write ports and status lines.
// The master modport is the sequencer; the slave side is the RAM/host fabric around it.
interface doc5503_osc_sequencer_if #(
    parameter int OSC_WIDTH  = 5,
    parameter int ACC_WIDTH  = 24,
    parameter int FREQ_WIDTH = 16
);
    logic                  start_i;
    logic [OSC_WIDTH-1:0]  osc_en_i;
    logic                  stall_i;
    logic [OSC_WIDTH-1:0]  osc_addr_o;
    logic [FREQ_WIDTH-1:0] freq_i;
    logic [7:0]            control_i;
    logic [ACC_WIDTH-1:0]  acc_i;
    logic                  acc_wr_req_o;
    logic [OSC_WIDTH-1:0]  acc_wr_addr_o;
    logic [ACC_WIDTH-1:0]  acc_wr_data_o;
    logic                  ctrl_wr_req_o;
    logic [OSC_WIDTH-1:0]  ctrl_wr_addr_o;
    logic [7:0]            ctrl_wr_data_o;
    logic                  irq_o;
    logic [OSC_WIDTH-1:0]  irq_osc_o;
    logic                  busy_o;
    logic                  frame_done_o;
    logic                  overrun_o;

    modport master (
        input  start_i, osc_en_i, stall_i, freq_i, control_i, acc_i,
        output osc_addr_o, acc_wr_req_o, acc_wr_addr_o, acc_wr_data_o,
               ctrl_wr_req_o, ctrl_wr_addr_o, ctrl_wr_data_o,
               irq_o, irq_osc_o, busy_o, frame_done_o, overrun_o
    );

    modport slave (
        output start_i, osc_en_i, stall_i, freq_i, control_i, acc_i,
        input  osc_addr_o, acc_wr_req_o, acc_wr_addr_o, acc_wr_data_o,
               ctrl_wr_req_o, ctrl_wr_addr_o, ctrl_wr_data_o,
               irq_o, irq_osc_o, busy_o, frame_done_o, overrun_o
    );
endinterface

// File: rtl/doc5503_osc_sequencer.sv
// Per-sample oscillator scan: reads freq/control/acc for each enabled oscillator,
// writes the advanced accumulator back and halts one-shot oscillators on overflow.
module doc5503_osc_sequencer #(
    parameter int OSC_WIDTH  = 5,
    parameter int ACC_WIDTH  = 24,
    parameter int FREQ_WIDTH = 16
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    doc5503_osc_sequencer_if.master bus
);

    typedef enum logic [1:0] {IDLE, ADDR, CALC, WRITE} state_t;

    state_t                 state_reg, state_next;
    logic [OSC_WIDTH-1:0]   osc_reg, osc_next;
    logic [OSC_WIDTH-1:0]   last_reg, last_next;
    logic [OSC_WIDTH-1:0]   osc_addr_reg, osc_addr_next;
    logic                   acc_wr_req_reg, acc_wr_req_next;
    logic [OSC_WIDTH-1:0]   acc_wr_addr_reg, acc_wr_addr_next;
    logic [ACC_WIDTH-1:0]   acc_wr_data_reg, acc_wr_data_next;
    logic                   ctrl_wr_req_reg, ctrl_wr_req_next;
    logic [OSC_WIDTH-1:0]   ctrl_wr_addr_reg, ctrl_wr_addr_next;
    logic [7:0]             ctrl_wr_data_reg, ctrl_wr_data_next;
    logic                   irq_reg, irq_next;
    logic [OSC_WIDTH-1:0]   irq_osc_reg, irq_osc_next;
    logic                   overrun_reg, overrun_next;
    logic                   frame_done;
    logic [ACC_WIDTH:0]     sum;
    logic                   ovf;
    logic                   at_last;

    // Frequency is zero-extended so the carry out of the accumulator lands in sum[ACC_WIDTH].
    assign sum     = {1'b0, bus.acc_i} + {{(ACC_WIDTH + 1 - FREQ_WIDTH){1'b0}}, bus.freq_i};
    assign ovf     = sum[ACC_WIDTH];
    assign at_last = (osc_reg == last_reg);

    always_comb begin
        state_next        = state_reg;
        osc_next          = osc_reg;
        last_next         = last_reg;
        acc_wr_req_next   = 1'b0;
        acc_wr_addr_next  = '0;
        acc_wr_data_next  = '0;
        ctrl_wr_req_next  = 1'b0;
        ctrl_wr_addr_next = '0;
        ctrl_wr_data_next = '0;
        irq_next          = 1'b0;
        irq_osc_next      = irq_osc_reg;
        frame_done        = 1'b0;
        overrun_next      = bus.start_i && (state_reg != IDLE);

        case (state_reg)
            IDLE: begin
                if (bus.start_i) begin
                    last_next  = bus.osc_en_i;
                    osc_next   = '0;
                    state_next = ADDR;
                end
            end
            ADDR: begin
                if (!bus.stall_i) begin
                    state_next = CALC;
                end
            end
            CALC: begin
                if (bus.control_i[0]) begin
                    if (at_last) begin
                        frame_done = 1'b1;
                        state_next = IDLE;
                    end else begin
                        osc_next   = osc_reg + 1'b1;
                        state_next = ADDR;
                    end
                end else begin
                    // Write-port values are registered here so they are presented during WRITE.
                    state_next       = WRITE;
                    acc_wr_req_next  = 1'b1;
                    acc_wr_addr_next = osc_reg;
                    if (ovf && bus.control_i[1]) begin
                        acc_wr_data_next  = '0;
                        ctrl_wr_req_next  = 1'b1;
                        ctrl_wr_addr_next = osc_reg;
                        ctrl_wr_data_next = bus.control_i | 8'h01;
                        if (bus.control_i[3]) begin
                            irq_next     = 1'b1;
                            irq_osc_next = osc_reg;
                        end
                    end else begin
                        acc_wr_data_next = sum[ACC_WIDTH-1:0];
                    end
                end
            end
            WRITE: begin
                if (at_last) begin
                    frame_done = 1'b1;
                    state_next = IDLE;
                end else begin
                    osc_next   = osc_reg + 1'b1;
                    state_next = ADDR;
                end
            end
            default: state_next = IDLE;
        endcase

        osc_addr_next = (state_next == IDLE) ? '0 : osc_next;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_reg        <= IDLE;
            osc_reg          <= '0;
            last_reg         <= '0;
            osc_addr_reg     <= '0;
            acc_wr_req_reg   <= 1'b0;
            acc_wr_addr_reg  <= '0;
            acc_wr_data_reg  <= '0;
            ctrl_wr_req_reg  <= 1'b0;
            ctrl_wr_addr_reg <= '0;
            ctrl_wr_data_reg <= '0;
            irq_reg          <= 1'b0;
            irq_osc_reg      <= '0;
            overrun_reg      <= 1'b0;
        end else begin
            state_reg        <= state_next;
            osc_reg          <= osc_next;
            last_reg         <= last_next;
            osc_addr_reg     <= osc_addr_next;
            acc_wr_req_reg   <= acc_wr_req_next;
            acc_wr_addr_reg  <= acc_wr_addr_next;
            acc_wr_data_reg  <= acc_wr_data_next;
            ctrl_wr_req_reg  <= ctrl_wr_req_next;
            ctrl_wr_addr_reg <= ctrl_wr_addr_next;
            ctrl_wr_data_reg <= ctrl_wr_data_next;
            irq_reg          <= irq_next;
            irq_osc_reg      <= irq_osc_next;
            overrun_reg      <= overrun_next;
        end
    end

    assign bus.osc_addr_o     = osc_addr_reg;
    assign bus.acc_wr_req_o   = acc_wr_req_reg;
    assign bus.acc_wr_addr_o  = acc_wr_addr_reg;
    assign bus.acc_wr_data_o  = acc_wr_data_reg;
    assign bus.ctrl_wr_req_o  = ctrl_wr_req_reg;
    assign bus.ctrl_wr_addr_o = ctrl_wr_addr_reg;
    assign bus.ctrl_wr_data_o = ctrl_wr_data_reg;
    assign bus.irq_o          = irq_reg;
    assign bus.irq_osc_o      = irq_osc_reg;
    assign bus.busy_o         = (state_reg != IDLE);
    assign bus.frame_done_o   = frame_done;
    assign bus.overrun_o      = overrun_reg;

endmodule
